// File: rtl/adder_pkg.sv
// rtl/adder_pkg.sv - shared digit width and FSM encodings for the digit-serial adder
package adder_pkg;

  localparam int DIGIT_W = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/rca2_slice.sv
// rtl/rca2_slice.sv - combinational 2-bit ripple-carry adder slice
module rca2_slice (
  input  logic [1:0] x,
  input  logic [1:0] y,
  input  logic       ci,
  output logic [1:0] s,
  output logic       co
);

  logic c1;

  assign s[0] = x[0] ^ y[0] ^ ci;
  assign c1   = (x[0] & y[0]) | (x[0] & ci) | (y[0] & ci);
  assign s[1] = x[1] ^ y[1] ^ c1;
  assign co   = (x[1] & y[1]) | (x[1] & c1) | (y[1] & c1);

endmodule

// File: rtl/digit_serial_adder.sv
// rtl/digit_serial_adder.sv - WIDTH-bit adder computed two bits per clock with valid/ready ports
module digit_serial_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int N     = WIDTH / DIGIT_W;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

  state_t             state;
  state_t             next_state;
  logic [CNT_W-1:0]   cnt;
  logic               carry;
  logic [WIDTH-1:0]   a_r;
  logic [WIDTH-1:0]   b_r;
  logic [WIDTH-1:0]   sum_r;
  logic               cout_r;

  // Digit i lives at bit 2i; appending a zero to the counter gives that offset.
  logic [CNT_W:0]     bit_idx;
  logic [1:0]         dig_a;
  logic [1:0]         dig_b;
  logic [1:0]         dig_s;
  logic               dig_co;

  assign bit_idx = {cnt, 1'b0};
  assign dig_a   = a_r[bit_idx +: DIGIT_W];
  assign dig_b   = b_r[bit_idx +: DIGIT_W];

  rca2_slice u_slice (
    .x  (dig_a),
    .y  (dig_b),
    .ci (carry),
    .s  (dig_s),
    .co (dig_co)
  );

  // State register; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; the spare encoding falls back to IDLE.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: if (in_valid)       next_state = ST_RUN;
      ST_RUN:  if (cnt == LAST)    next_state = ST_DONE;
      ST_DONE: if (out_ready)      next_state = ST_IDLE;
      default:                     next_state = ST_IDLE;
    endcase
  end

  // Handshake and status outputs decoded from the state register.
  always_comb begin
    in_ready  = (state == ST_IDLE);
    out_valid = (state == ST_DONE);
    busy      = (state == ST_RUN) || (state == ST_DONE);
  end

  // Operand capture, one digit per RUN cycle; the counter stops at the last digit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r    <= '0;
      b_r    <= '0;
      sum_r  <= '0;
      cout_r <= 1'b0;
      carry  <= 1'b0;
      cnt    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            a_r    <= a;
            b_r    <= b;
            carry  <= cin;
            cnt    <= '0;
            sum_r  <= '0;
            cout_r <= 1'b0;
          end
        end
        ST_RUN: begin
          sum_r[bit_idx +: DIGIT_W] <= dig_s;
          carry                     <= dig_co;
          if (cnt == LAST) begin
            cout_r <= dig_co;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign sum  = sum_r;
  assign cout = cout_r;

endmodule

// File: tb/tb_digit_serial_adder.sv
// tb/tb_digit_serial_adder.sv - self-checking bench for digit_serial_adder
module tb_digit_serial_adder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, in_ready, cin, out_valid, out_ready, cout, busy;
  logic [7:0] a, b, sum;
  logic       in_valid2, in_ready2, cin2, out_valid2, out_ready2, cout2, busy2;
  logic [1:0] a2, b2, sum2;

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [8:0] sb_q[$];

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] sum;
    logic       cout;
  } vec_t;

  vec_t vecs[8];

  digit_serial_adder #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .busy(busy)
  );

  digit_serial_adder #(.WIDTH(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2),
    .a(a2), .b(b2), .cin(cin2), .out_valid(out_valid2), .out_ready(out_ready2),
    .sum(sum2), .cout(cout2), .busy(busy2)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic accept(input logic [7:0] va, input logic [7:0] vb, input logic vc,
                        input logic [8:0] exp);
    @(negedge clk);
    in_valid = 1'b1; a = va; b = vb; cin = vc;
    check("in_ready_before_accept", {31'd0, in_ready}, 32'd1);
    sb_q.push_back(exp);
    @(negedge clk);
    in_valid = 1'b0;
    a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
    check("busy_after_accept", {31'd0, busy}, 32'd1);
  endtask

  task automatic wait_result(input int exp_lat, input string tag);
    int lat = 0;
    logic [8:0] exp;
    while (!out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_out_valid"}, {31'd0, out_valid}, 32'd1);
    check({tag, "_pending"}, sb_q.size(), 32'd1);
    if (sb_q.size() > 0) begin
      exp = sb_q.pop_front();
      check({tag, "_sum"}, {24'd0, sum}, {24'd0, exp[7:0]});
      check({tag, "_cout"}, {31'd0, cout}, {31'd0, exp[8]});
    end
  endtask

  task automatic after_handshake(input string tag);
    @(negedge clk);
    check({tag, "_hs_out_valid"}, {31'd0, out_valid}, 32'd0);
    check({tag, "_hs_in_ready"}, {31'd0, in_ready}, 32'd1);
    check({tag, "_hs_busy"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    logic [7:0] ra, rb;
    logic       rc;

    rst_n = 1'b0;
    in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; out_ready = 1'b1;
    in_valid2 = 1'b0; a2 = '0; b2 = '0; cin2 = 1'b0; out_ready2 = 1'b1;

    vecs[0] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    vecs[2] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
    vecs[3] = '{8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1};
    vecs[4] = '{8'hA5, 8'h5A, 1'b0, 8'hFF, 1'b0};
    vecs[5] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0};
    vecs[6] = '{8'h3C, 8'hC4, 1'b1, 8'h01, 1'b1};
    vecs[7] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0};

    repeat (2) @(negedge clk);
    check("rst_sum", {24'd0, sum}, 32'd0);
    check("rst_cout", {31'd0, cout}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("post_rst_out_valid", {31'd0, out_valid}, 32'd0);

    for (int i = 0; i < 8; i++) begin
      accept(vecs[i].a, vecs[i].b, vecs[i].cin, {vecs[i].cout, vecs[i].sum});
      wait_result(4, $sformatf("vec%0d", i));
      after_handshake($sformatf("vec%0d", i));
    end

    for (int i = 0; i < 4; i++) begin
      ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
      accept(ra, rb, rc, {1'b0, ra} + {1'b0, rb} + {8'd0, rc});
      wait_result(4, $sformatf("rand%0d", i));
      after_handshake($sformatf("rand%0d", i));
    end

    // Back-pressure: DONE must hold while new operands are offered.
    out_ready = 1'b0;
    accept(8'h3C, 8'h0F, 1'b0, {1'b0, 8'h4B});
    wait_result(4, "bp");
    in_valid = 1'b1; a = 8'h11; b = 8'h22; cin = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_hold_out_valid", {31'd0, out_valid}, 32'd1);
      check("bp_hold_sum", {24'd0, sum}, 32'h4B);
      check("bp_hold_cout", {31'd0, cout}, 32'd0);
      check("bp_hold_in_ready", {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    sb_q.push_back({1'b0, 8'h33});
    @(negedge clk);
    check("bp_release_out_valid", {31'd0, out_valid}, 32'd0);
    check("bp_release_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    check("bp_next_busy", {31'd0, busy}, 32'd1);
    wait_result(4, "bp_next");
    after_handshake("bp_next");

    // Reset two digits into FF+FF.
    @(negedge clk);
    in_valid = 1'b1; a = 8'hFF; b = 8'hFF; cin = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("midrun_partial_sum", {24'd0, sum}, 32'h0E);
    check("midrun_busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort_sum", {24'd0, sum}, 32'd0);
    check("abort_cout", {31'd0, cout}, 32'd0);
    check("abort_out_valid", {31'd0, out_valid}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    accept(8'h12, 8'h34, 1'b0, {1'b0, 8'h46});
    wait_result(4, "post_abort");
    after_handshake("post_abort");

    // Single-digit instance.
    @(negedge clk);
    in_valid2 = 1'b1; a2 = 2'b11; b2 = 2'b01; cin2 = 1'b1;
    check("w2_in_ready", {31'd0, in_ready2}, 32'd1);
    @(negedge clk);
    in_valid2 = 1'b0;
    check("w2_busy", {31'd0, busy2}, 32'd1);
    @(negedge clk);
    check("w2_out_valid", {31'd0, out_valid2}, 32'd1);
    check("w2_sum", {30'd0, sum2}, 32'd1);
    check("w2_cout", {31'd0, cout2}, 32'd1);
    @(negedge clk);
    check("w2_hs_out_valid", {31'd0, out_valid2}, 32'd0);
    check("w2_hs_in_ready", {31'd0, in_ready2}, 32'd1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/digit_serial_adder.md
Name: digit_serial_adder

Overview:
Multi-cycle WIDTH-bit adder. It accepts a full operand pair through a valid/ready handshake. It then processes the operands two bits per clock through a 2-bit ripple-carry slice, with the carry registered between digits. The WIDTH-bit sum and carry-out are presented on a valid/ready result port. It sits upstream of the 2-bit adder datapath, sequencing wide operands into narrow digit additions, and trades latency for minimal adder area.

Parameters:
WIDTH, 8, operand/sum width in bits; must be even and >= 2.
CNT_W, $clog2(WIDTH/2) (minimum 1), width of the digit counter; derived, not overridden.

Ports:
clk        input   1      rising-edge clock
rst_n      input   1      asynchronous active-low reset
in_valid   input   1      operand pair valid
in_ready   output  1      block can accept operands
a          input   WIDTH  operand A
b          input   WIDTH  operand B
cin        input   1      carry-in to digit 0
out_valid  output  1      sum/cout valid
out_ready  input   1      consumer accepts result
sum        output  WIDTH  (a + b + cin) mod 2^WIDTH
cout       output  1      bit WIDTH of a + b + cin
busy       output  1      high in RUN or DONE

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE, digit counter=0, carry reg=0, operand regs=0.
  - sum=0, cout=0, out_valid=0, busy=0, in_ready=1 after deassertion.
- Arithmetic: N = WIDTH/2 digits, least-significant digit first.
  - Digit i uses a[2i+1:2i], b[2i+1:2i] and the carry reg.
  - The 2-bit result goes to sum[2i+1:2i]; the slice carry-out updates the carry reg.
  - cout = carry reg after digit N-1. No overflow flag.
- FSM states IDLE, RUN, DONE:
  - IDLE: in_ready=1. On edge with in_valid=1: latch a, b; carry reg<=cin; counter<=0; sum<=0; cout<=0; go to RUN.
  - RUN: in_ready=0, busy=1. Each edge processes digit[counter] and increments the counter.
  - RUN, at the edge processing digit N-1: write cout; go to DONE; out_valid<=1.
  - DONE: out_valid=1; sum and cout held stable. On edge with out_ready=1: out_valid<=0; go to IDLE.
- Latency:
  - Operands accepted at edge t; out_valid rises after edge t+N.
  - With out_ready held high: result handshake at edge t+N+1, next acceptance no earlier than edge t+N+2. Throughput is 1 op per N+2 cycles.
- Boundary conditions:
  - in_valid in RUN/DONE is ignored; no overlap and no buffering.
  - out_ready while out_valid=0 has no effect.
  - Back-pressure: DONE holds indefinitely; outputs must not change.
  - Counter reaches exactly N-1 and never wraps within an operation.
  - rst_n asserted mid-RUN or in DONE aborts the operation immediately to IDLE. The partial result is discarded and all outputs are zeroed.
  - Operand inputs may change freely after the acceptance edge; only the latched copies are used.
- sum bits not yet processed read 0 during RUN; consumers must only sample on out_valid.

Decomposition:
- Shared package adder_pkg:
  - DIGIT_W=2.
  - State encodings: ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2.
  - An unused encoding recovers to IDLE.
- One sub-module, rca2_slice: purely combinational 2-bit ripple-carry slice.
  - Inputs x[1:0], y[1:0], ci; outputs s[1:0], co.
  - Instantiated once; reusable and separately testable.
- FSM, counter, carry reg and operand/sum regs live in digit_serial_adder.

Test Plan:
- WIDTH=8, a=8'h00, b=8'h00, cin=0, out_ready=1 -> out_valid exactly 4 cycles after accept; sum=8'h00, cout=0; in_ready back high 1 cycle after result handshake.
- a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1 (carry ripples through all 4 digits); a=8'h80, b=8'h80 -> sum=8'h00, cout=1.
- a=8'hA5, b=8'h5A, cin=1 -> sum=8'h00, cout=1; same operands with cin=0 -> sum=8'hFF, cout=0.
- Back-pressure: out_ready=0 for 5 cycles after out_valid, with in_valid=1 and new operands driven -> sum/cout/out_valid stable, in_ready=0, new operands not taken. Raise out_ready -> handshake, then new operands accepted.
- Pull rst_n low for 1 cycle mid-RUN after 2 digits of a=8'hFF, b=8'hFF -> all outputs 0 immediately, state IDLE. Then a=8'h12, b=8'h34, cin=0 -> sum=8'h46, cout=0.
- WIDTH=2 instance: a=2'b11, b=2'b01, cin=1 -> sum=2'b01, cout=1, out_valid 1 cycle after accept.
